// File: rtl/data_packer_mp_if.sv
// data_packer_mp_if
//   Bundles the trace-side and configuration-side signals of data_packer_mp.
//   master : the driver of trace/config traffic (filter stage / bench)
//   slave  : the packer itself
// Signals:
//   tracing              1 = trace mode, 0 = configuration mode
//   valid_in             vector_in valid
//   eof_in, bof_in       end/begin-of-frame flags, two each
//   chainId_in           firmware table entry selector
//   configId, configData configuration bus
//   vector_in            N values of DATA_WIDTH bits
//   vector_out           packed output vector
//   valid_out            one-cycle pulse per output vector
//   partial_out          with valid_out: upper slots are zero padding
//   fill_level           slots currently held
interface data_packer_mp_if #(
  parameter int N          = 8,
  parameter int DATA_WIDTH = 32,
  parameter int PRECISION  = 2,
  parameter int MAX_CHAINS = 4
);
  localparam int CW  = (MAX_CHAINS > 1) ? $clog2(MAX_CHAINS) : 1;
  localparam int FLW = $clog2(N * PRECISION + 1);

  logic                    tracing;
  logic                    valid_in;
  logic [1:0]              eof_in;
  logic [1:0]              bof_in;
  logic [CW-1:0]           chainId_in;
  logic [7:0]              configId;
  logic [7:0]              configData;
  logic [N*DATA_WIDTH-1:0] vector_in;
  logic [N*DATA_WIDTH-1:0] vector_out;
  logic                    valid_out;
  logic                    partial_out;
  logic [FLW-1:0]          fill_level;

  modport master (
    output tracing, valid_in, eof_in, bof_in, chainId_in, configId, configData, vector_in,
    input  vector_out, valid_out, partial_out, fill_level
  );

  modport slave (
    input  tracing, valid_in, eof_in, bof_in, chainId_in, configId, configData, vector_in,
    output vector_out, valid_out, partial_out, fill_level
  );
endinterface

// File: rtl/data_packer_mp.sv
// data_packer_mp
//   Packs trace vectors into full-width output vectors at reduced precision
//   (PRECISION values of DATA_WIDTH/PRECISION bits per output word). Each
//   chain has a firmware mode (block of N, M or 1 values, bypass, or drop) and
//   an accept condition on the frame flags. A partial vector is emitted when a
//   block does not fit, and flushed when tracing stops.
// Ports:
//   clk  clock
//   rst  asynchronous active-high reset
//   bus  data_packer_mp_if.slave (trace inputs, config bus, packed outputs)
module data_packer_mp #(
  parameter int                      N                     = 8,
  parameter int                      M                     = 2,
  parameter int                      DATA_WIDTH            = 32,
  parameter int                      PRECISION             = 2,
  parameter int                      MAX_CHAINS            = 4,
  parameter logic [7:0]              PERSONAL_CONFIG_ID    = 8'd0,
  parameter logic [8*MAX_CHAINS-1:0] INITIAL_FIRMWARE      = '0,
  parameter logic [8*MAX_CHAINS-1:0] INITIAL_FIRMWARE_COND = '0
) (
  input logic              clk,
  input logic              rst,
  data_packer_mp_if.slave  bus
);
  localparam int BW  = DATA_WIDTH / PRECISION;
  localparam int NS  = N * PRECISION;
  localparam int VW  = N * DATA_WIDTH;
  localparam int FLW = $clog2(NS + 1);

  // Slot k lives at bits [k*BW +: BW], which is exactly the output word layout,
  // so the slot store doubles as the packed output image. Slots at or above
  // fill are always zero, which lets new blocks be OR-ed in.
  logic [VW-1:0]  slots_reg, slots_next;
  logic [FLW-1:0] fill_reg, fill_next;
  logic [VW-1:0]  vector_out_reg, vector_out_next;
  logic           valid_out_reg, valid_out_next;
  logic           partial_out_reg, partial_out_next;
  logic           tracing_reg;
  logic [7:0]     byte_cnt_reg;
  logic [7:0]     cond_table [MAX_CHAINS];
  logic [7:0]     mode_table [MAX_CHAINS];

  logic [7:0] mode, cond, flag_hits;
  logic       accept, bypass, flush, cfg_hit;
  int         len_i, total_i;
  logic [VW-1:0] block, appended;

  // Table lookup and accept decision for the current beat.
  always_comb begin
    mode      = mode_table[bus.chainId_in];
    cond      = cond_table[bus.chainId_in];
    flag_hits = cond & {~bus.bof_in[1], bus.bof_in[1], ~bus.eof_in[1], bus.eof_in[1],
                        ~bus.bof_in[0], bus.bof_in[0], ~bus.eof_in[0], bus.eof_in[0]};
    accept    = bus.valid_in && bus.tracing && (mode <= 8'd3) &&
                ((cond == 8'd0) || (flag_hits != 8'd0));
    bypass    = (mode == 8'd3);
    flush     = tracing_reg && !bus.tracing;
    case (mode)
      8'd0:    len_i = N;
      8'd1:    len_i = M;
      default: len_i = 1;
    endcase
    total_i = 32'(fill_reg) + len_i;
  end

  assign cfg_hit = !bus.tracing && (bus.configId == PERSONAL_CONFIG_ID);

  // Incoming block aligned to slot 0: low BW bits of the first len_i lanes.
  for (genvar gi = 0; gi < N; gi++) begin : g_block
    assign block[gi*BW +: BW] = (gi < len_i) ? bus.vector_in[gi*DATA_WIDTH +: BW] : '0;
  end
  if (PRECISION > 1) begin : g_block_pad
    assign block[VW-1:N*BW] = '0;
  end

  // Only meaningful when the block fits; the shift drops anything beyond NS.
  assign appended = slots_reg | (block << (32'(fill_reg) * BW));

  always_comb begin
    slots_next       = slots_reg;
    fill_next        = fill_reg;
    vector_out_next  = vector_out_reg;
    valid_out_next   = 1'b0;
    partial_out_next = 1'b0;
    if (flush) begin
      if (fill_reg != '0) begin
        valid_out_next   = 1'b1;
        partial_out_next = 1'b1;
        vector_out_next  = slots_reg;
      end
      slots_next = '0;
      fill_next  = '0;
    end else if (accept) begin
      if (bypass) begin
        valid_out_next  = 1'b1;
        vector_out_next = bus.vector_in;
      end else if (total_i > NS) begin
        valid_out_next   = 1'b1;
        partial_out_next = 1'b1;
        vector_out_next  = slots_reg;
        slots_next       = block;
        fill_next        = FLW'(len_i);
      end else if (total_i == NS) begin
        valid_out_next  = 1'b1;
        vector_out_next = appended;
        slots_next      = '0;
        fill_next       = '0;
      end else begin
        slots_next = appended;
        fill_next  = FLW'(total_i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slots_reg       <= '0;
      fill_reg        <= '0;
      vector_out_reg  <= '0;
      valid_out_reg   <= 1'b0;
      partial_out_reg <= 1'b0;
      tracing_reg     <= 1'b0;
      byte_cnt_reg    <= '0;
    end else begin
      slots_reg       <= slots_next;
      fill_reg        <= fill_next;
      vector_out_reg  <= vector_out_next;
      valid_out_reg   <= valid_out_next;
      partial_out_reg <= partial_out_next;
      tracing_reg     <= bus.tracing;
      if (!bus.tracing) begin
        // Saturate so trailing bytes never wrap back into the tables.
        if (cfg_hit) begin
          if (byte_cnt_reg != 8'hFF) byte_cnt_reg <= byte_cnt_reg + 8'd1;
        end else begin
          byte_cnt_reg <= '0;
        end
      end
    end
  end

  // Byte b < MAX_CHAINS writes cond[b]; MAX_CHAINS <= b < 2*MAX_CHAINS writes mode[b-MAX_CHAINS].
  for (genvar gi = 0; gi < MAX_CHAINS; gi++) begin : g_tables
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cond_table[gi] <= INITIAL_FIRMWARE_COND[gi*8 +: 8];
        mode_table[gi] <= INITIAL_FIRMWARE[gi*8 +: 8];
      end else if (cfg_hit) begin
        if (byte_cnt_reg == 8'(gi))              cond_table[gi] <= bus.configData;
        if (byte_cnt_reg == 8'(MAX_CHAINS + gi)) mode_table[gi] <= bus.configData;
      end
    end
  end

  assign bus.vector_out  = vector_out_reg;
  assign bus.valid_out   = valid_out_reg;
  assign bus.partial_out = partial_out_reg;
  assign bus.fill_level  = fill_reg;
endmodule

// File: tb/tb_data_packer_mp.sv
module tb_data_packer_mp;
  localparam int N  = 8;
  localparam int DW = 32;
  localparam int P  = 2;
  localparam int BW = DW / P;
  localparam int NS = N * P;
  localparam int VW = N * DW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_packer_mp_if #(.N(N), .DATA_WIDTH(DW), .PRECISION(P), .MAX_CHAINS(4)) bus ();

  // Chain 0: singles, chain 1: medium blocks, chain 2: full vectors, chain 3: bypass.
  data_packer_mp #(
    .N(N), .M(2), .DATA_WIDTH(DW), .PRECISION(P), .MAX_CHAINS(4),
    .PERSONAL_CONFIG_ID(8'h00),
    .INITIAL_FIRMWARE({8'd3, 8'd0, 8'd1, 8'd2}),
    .INITIAL_FIRMWARE_COND(32'h0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: queue of held reduced-precision values plus the tables.
  logic [BW-1:0] held[$];
  logic [7:0]    m_mode [4];
  logic [7:0]    m_cond [4];
  int            m_bc;
  logic          m_trace_prev;
  logic          exp_valid, exp_partial;
  logic [VW-1:0] exp_vec;
  int            exp_fill;

  function automatic logic [VW-1:0] held_vector();
    logic [VW-1:0] v = '0;
    for (int i = 0; i < held.size(); i++) v[i*BW +: BW] = held[i];
    return v;
  endfunction

  function automatic logic [31:0] out_word(input int i);
    logic [VW-1:0] v = bus.vector_out;
    return v[i*DW +: DW];
  endfunction

  function automatic bit cond_ok(input logic [7:0] c, input logic [1:0] e, input logic [1:0] b);
    bit   ok;
    logic flag;
    ok = (c == 8'd0);
    for (int k = 0; k < 8; k++) begin
      flag = (k < 4) ? ((k < 2) ? e[0] : b[0]) : ((k < 6) ? e[1] : b[1]);
      if (c[k] && (flag == ((k % 2) == 0))) ok = 1'b1;
    end
    return ok;
  endfunction

  task automatic model_reset();
    held.delete();
    m_mode       = '{8'd2, 8'd1, 8'd0, 8'd3};
    m_cond       = '{default: 8'd0};
    m_bc         = 0;
    m_trace_prev = 1'b0;
    exp_valid    = 1'b0;
    exp_partial  = 1'b0;
    exp_vec      = '0;
    exp_fill     = 0;
  endtask

  task automatic drive_idle();
    bus.tracing    = 1'b0;
    bus.valid_in   = 1'b0;
    bus.eof_in     = 2'b00;
    bus.bof_in     = 2'b00;
    bus.chainId_in = 2'd0;
    bus.configId   = 8'hFF;
    bus.configData = 8'h00;
    bus.vector_in  = '0;
  endtask

  task automatic random_vector();
    for (int l = 0; l < N; l++) bus.vector_in[l*DW +: DW] = $urandom;
  endtask

  // Applies the current inputs to the model, advances one clock, settles.
  task automatic tick();
    logic [7:0] md;
    int         len;
    exp_valid   = 1'b0;
    exp_partial = 1'b0;
    if (m_trace_prev && !bus.tracing) begin
      if (held.size() > 0) begin
        exp_valid = 1'b1; exp_partial = 1'b1; exp_vec = held_vector();
      end
      held.delete();
    end else if (bus.valid_in && bus.tracing) begin
      md = m_mode[bus.chainId_in];
      if (md <= 8'd3 && cond_ok(m_cond[bus.chainId_in], bus.eof_in, bus.bof_in)) begin
        if (md == 8'd3) begin
          exp_valid = 1'b1; exp_vec = bus.vector_in;
        end else begin
          len = (md == 8'd0) ? N : (md == 8'd1) ? 2 : 1;
          if (held.size() + len > NS) begin
            exp_valid = 1'b1; exp_partial = 1'b1; exp_vec = held_vector();
            held.delete();
          end
          for (int j = 0; j < len; j++) held.push_back(bus.vector_in[j*DW +: BW]);
          if (held.size() == NS) begin
            exp_valid = 1'b1; exp_vec = held_vector();
            held.delete();
          end
        end
      end
    end
    if (!bus.tracing) begin
      if (bus.configId == 8'h00) begin
        if (m_bc < 4)      m_cond[m_bc] = bus.configData;
        else if (m_bc < 8) m_mode[m_bc-4] = bus.configData;
        m_bc++;
      end else begin
        m_bc = 0;
      end
    end
    m_trace_prev = bus.tracing;
    @(posedge clk);
    #1;
    exp_fill = held.size();
    if (bus.valid_out)
      $display("emit t=%0t partial=%0b fill=%0d word0=%h word7=%h",
               $time, bus.partial_out, bus.fill_level, out_word(0), out_word(7));
  endtask

  task automatic test_reset();
    drive_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.valid_out !== 1'b0)   begin errors++; $display("FAIL reset_valid got=%b exp=0", bus.valid_out); end
    checks++; if (bus.partial_out !== 1'b0) begin errors++; $display("FAIL reset_partial got=%b exp=0", bus.partial_out); end
    checks++; if (bus.vector_out !== '0)    begin errors++; $display("FAIL reset_vector got=%h exp=0", bus.vector_out); end
    checks++; if (bus.fill_level !== 5'd0)  begin errors++; $display("FAIL reset_fill got=%0d exp=0", bus.fill_level); end
    rst = 1'b0;
    model_reset();
    tick();
  endtask

  task automatic test_single_mode();
    bus.tracing = 1'b1; bus.chainId_in = 2'd0; bus.valid_in = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      random_vector();
      bus.vector_in[31:0] = 32'(k);
      tick();
      if (k < 16) begin
        checks++; if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL single_early_valid beat=%0d got=%b exp=0", k, bus.valid_out); end
        checks++; if (bus.fill_level !== 5'(k)) begin errors++; $display("FAIL single_fill beat=%0d got=%0d exp=%0d", k, bus.fill_level, k); end
      end else begin
        checks++; if (bus.valid_out !== 1'b1)     begin errors++; $display("FAIL single_valid got=%b exp=1", bus.valid_out); end
        checks++; if (bus.partial_out !== 1'b0)   begin errors++; $display("FAIL single_partial got=%b exp=0", bus.partial_out); end
        checks++; if (out_word(0) !== 32'h00020001) begin errors++; $display("FAIL single_word0 got=%h exp=00020001", out_word(0)); end
        checks++; if (out_word(7) !== 32'h0010000F) begin errors++; $display("FAIL single_word7 got=%h exp=0010000f", out_word(7)); end
        checks++; if (bus.vector_out !== exp_vec) begin errors++; $display("FAIL single_vector got=%h exp=%h", bus.vector_out, exp_vec); end
        checks++; if (bus.fill_level !== 5'd0)    begin errors++; $display("FAIL single_fill_end got=%0d exp=0", bus.fill_level); end
      end
    end
  endtask

  task automatic test_medium_mode();
    bus.chainId_in = 2'd1;
    for (int k = 0; k < 8; k++) begin
      random_vector();
      // Upper bits are junk: only the low half of each value is kept.
      bus.vector_in[15:0]  = 16'(2*k);
      bus.vector_in[47:32] = 16'(2*k + 1);
      tick();
      if (k < 7) begin
        checks++; if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL medium_early_valid beat=%0d got=%b exp=0", k, bus.valid_out); end
      end else begin
        checks++; if (bus.valid_out !== 1'b1) begin errors++; $display("FAIL medium_valid got=%b exp=1", bus.valid_out); end
        checks++; if (out_word(0) !== 32'h00010000) begin errors++; $display("FAIL medium_word0 got=%h exp=00010000", out_word(0)); end
        checks++; if (bus.vector_out !== exp_vec) begin errors++; $display("FAIL medium_vector got=%h exp=%h", bus.vector_out, exp_vec); end
      end
    end
  endtask

  task automatic test_overflow_partial();
    bus.chainId_in = 2'd0;
    for (int k = 1; k <= 15; k++) begin
      random_vector(); bus.vector_in[31:0] = 32'(k); tick();
    end
    checks++; if (bus.fill_level !== 5'd15) begin errors++; $display("FAIL overflow_prefill got=%0d exp=15", bus.fill_level); end
    bus.chainId_in = 2'd2;
    for (int l = 0; l < N; l++) bus.vector_in[l*DW +: DW] = 32'h0000AAAA;
    tick();
    checks++; if (bus.valid_out !== 1'b1)   begin errors++; $display("FAIL overflow_valid got=%b exp=1", bus.valid_out); end
    checks++; if (bus.partial_out !== 1'b1) begin errors++; $display("FAIL overflow_partial got=%b exp=1", bus.partial_out); end
    checks++; if (out_word(7) !== 32'h0000000F) begin errors++; $display("FAIL overflow_word7 got=%h exp=0000000f", out_word(7)); end
    checks++; if (bus.vector_out !== exp_vec) begin errors++; $display("FAIL overflow_vector got=%h exp=%h", bus.vector_out, exp_vec); end
    checks++; if (bus.fill_level !== 5'd8)  begin errors++; $display("FAIL overflow_fill got=%0d exp=8", bus.fill_level); end
  endtask

  task automatic test_flush();
    bus.tracing = 1'b0; bus.valid_in = 1'b0;
    tick();
    checks++; if (bus.valid_out !== 1'b1 || bus.partial_out !== 1'b1) begin errors++; $display("FAIL flush8_flags got=%b%b exp=11", bus.valid_out, bus.partial_out); end
    checks++; if (out_word(0) !== 32'hAAAAAAAA) begin errors++; $display("FAIL flush8_word0 got=%h exp=aaaaaaaa", out_word(0)); end
    bus.tracing = 1'b1; bus.valid_in = 1'b1; bus.chainId_in = 2'd0;
    for (int k = 5; k <= 7; k++) begin
      random_vector(); bus.vector_in[31:0] = 32'(k); tick();
    end
    // The beat presented on the flush cycle must be ignored.
    bus.tracing = 1'b0; bus.vector_in[31:0] = 32'd9;
    tick();
    checks++; if (bus.valid_out !== 1'b1)   begin errors++; $display("FAIL flush_valid got=%b exp=1", bus.valid_out); end
    checks++; if (bus.partial_out !== 1'b1) begin errors++; $display("FAIL flush_partial got=%b exp=1", bus.partial_out); end
    checks++; if (out_word(0) !== 32'h00060005) begin errors++; $display("FAIL flush_word0 got=%h exp=00060005", out_word(0)); end
    checks++; if (out_word(1) !== 32'h00000007) begin errors++; $display("FAIL flush_word1 got=%h exp=00000007", out_word(1)); end
    checks++; if (bus.vector_out[VW-1:64] !== '0) begin errors++; $display("FAIL flush_upper got=%h exp=0", bus.vector_out[VW-1:64]); end
    checks++; if (bus.fill_level !== 5'd0)  begin errors++; $display("FAIL flush_fill got=%0d exp=0", bus.fill_level); end
    tick();
    checks++; if (bus.valid_out !== 1'b0)   begin errors++; $display("FAIL flush_once got=%b exp=0", bus.valid_out); end
    checks++; if (bus.fill_level !== 5'd0)  begin errors++; $display("FAIL flush_ignored_beat got=%0d exp=0", bus.fill_level); end
  endtask

  task automatic test_bypass();
    logic [VW-1:0] vin;
    bus.tracing = 1'b1; bus.valid_in = 1'b1; bus.chainId_in = 2'd0;
    for (int k = 0; k < 4; k++) begin random_vector(); tick(); end
    checks++; if (bus.fill_level !== 5'd4) begin errors++; $display("FAIL bypass_prefill got=%0d exp=4", bus.fill_level); end
    bus.chainId_in = 2'd3;
    random_vector();
    vin = bus.vector_in;
    tick();
    checks++; if (bus.valid_out !== 1'b1)   begin errors++; $display("FAIL bypass_valid got=%b exp=1", bus.valid_out); end
    checks++; if (bus.partial_out !== 1'b0) begin errors++; $display("FAIL bypass_partial got=%b exp=0", bus.partial_out); end
    checks++; if (bus.vector_out !== vin)   begin errors++; $display("FAIL bypass_vector got=%h exp=%h", bus.vector_out, vin); end
    checks++; if (bus.fill_level !== 5'd4)  begin errors++; $display("FAIL bypass_fill got=%0d exp=4", bus.fill_level); end
    bus.tracing = 1'b0; bus.valid_in = 1'b0;
    tick();
    checks++; if (bus.vector_out !== exp_vec || bus.valid_out !== exp_valid) begin errors++; $display("FAIL bypass_flush got=%h exp=%h", bus.vector_out, exp_vec); end
  endtask

  task automatic test_config();
    logic [7:0] cfg [8];
    cfg = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd2, 8'd0, 8'd0, 8'd0};
    bus.tracing = 1'b0; bus.valid_in = 1'b0; bus.configId = 8'h05;
    tick();
    bus.configId = 8'h00;
    for (int b = 0; b < 8; b++) begin bus.configData = cfg[b]; tick(); end
    bus.configId = 8'hFF; bus.configData = 8'h77;
    tick();
    bus.tracing = 1'b1; bus.valid_in = 1'b1; bus.chainId_in = 2'd0;
    random_vector(); bus.eof_in = 2'b00;
    tick();
    checks++; if (bus.fill_level !== 5'd0) begin errors++; $display("FAIL cond_reject got=%0d exp=0", bus.fill_level); end
    random_vector(); bus.eof_in = 2'b01;
    tick();
    checks++; if (bus.fill_level !== 5'd1) begin errors++; $display("FAIL cond_accept got=%0d exp=1", bus.fill_level); end
    random_vector(); bus.eof_in = 2'b10;
    tick();
    checks++; if (bus.fill_level !== 5'd1) begin errors++; $display("FAIL cond_eof1_reject got=%0d exp=1", bus.fill_level); end
    // Chain 3 was bypass; the config rewrote it to full-vector mode.
    bus.chainId_in = 2'd3; bus.eof_in = 2'b00; random_vector();
    tick();
    checks++; if (bus.valid_out !== 1'b0)  begin errors++; $display("FAIL cfg_mode_valid got=%b exp=0", bus.valid_out); end
    checks++; if (bus.fill_level !== 5'd9) begin errors++; $display("FAIL cfg_mode_fill got=%0d exp=9", bus.fill_level); end
  endtask

  task automatic test_reset_midfill();
    bus.chainId_in = 2'd1; random_vector();
    tick();
    checks++; if (bus.valid_out !== 1'b1 || bus.fill_level !== 5'd8) begin errors++; $display("FAIL midfill_pre got=%b/%0d exp=1/8", bus.valid_out, bus.fill_level); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.valid_out !== 1'b0)   begin errors++; $display("FAIL async_valid got=%b exp=0", bus.valid_out); end
    checks++; if (bus.partial_out !== 1'b0) begin errors++; $display("FAIL async_partial got=%b exp=0", bus.partial_out); end
    checks++; if (bus.vector_out !== '0)    begin errors++; $display("FAIL async_vector got=%h exp=0", bus.vector_out); end
    checks++; if (bus.fill_level !== 5'd0)  begin errors++; $display("FAIL async_fill got=%0d exp=0", bus.fill_level); end
    drive_idle();
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    tick();
    checks++; if (bus.valid_out !== 1'b0 || bus.fill_level !== 5'd0) begin errors++; $display("FAIL reset_no_flush got=%b/%0d exp=0/0", bus.valid_out, bus.fill_level); end
  endtask

  task automatic test_random();
    bus.tracing = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0) bus.tracing = ~bus.tracing;
      bus.valid_in   = ($urandom_range(0, 9) < 7);
      bus.chainId_in = 2'($urandom_range(0, 3));
      bus.eof_in     = 2'($urandom_range(0, 3));
      bus.bof_in     = 2'($urandom_range(0, 3));
      bus.configId   = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'h33;
      bus.configData = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 5)) : 8'($urandom_range(0, 255));
      random_vector();
      tick();
      checks++; if (bus.valid_out !== exp_valid) begin errors++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", c, bus.valid_out, exp_valid); end
      checks++; if (bus.fill_level !== 5'(exp_fill)) begin errors++; $display("FAIL rand_fill cyc=%0d got=%0d exp=%0d", c, bus.fill_level, exp_fill); end
      if (exp_valid) begin
        checks++; if (bus.partial_out !== exp_partial) begin errors++; $display("FAIL rand_partial cyc=%0d got=%b exp=%b", c, bus.partial_out, exp_partial); end
        checks++; if (bus.vector_out !== exp_vec) begin errors++; $display("FAIL rand_vector cyc=%0d got=%h exp=%h", c, bus.vector_out, exp_vec); end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_mode();
    test_medium_mode();
    test_overflow_partial();
    test_flush();
    test_bypass();
    test_config();
    test_reset_midfill();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
